// File: rtl/snake_pkg.sv
// Direction encodings and helpers shared by the snake movement controller,
// datapath and control FSM.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_LEFT  = 3'b000,
    DIR_RIGHT = 3'b001,
    DIR_UP    = 3'b100,
    DIR_DOWN  = 3'b110
  } dir_e;

  // True when b points exactly against a (a 180 degree reversal).
  function automatic logic dir_opposite(input dir_e a, input dir_e b);
    logic opp_s;
    case (a)
      DIR_UP:    opp_s = (b == DIR_DOWN);
      DIR_DOWN:  opp_s = (b == DIR_UP);
      DIR_LEFT:  opp_s = (b == DIR_RIGHT);
      DIR_RIGHT: opp_s = (b == DIR_LEFT);
      default:   opp_s = 1'b0;
    endcase
    return opp_s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-FF synchronizer, stable-run debouncer and a
// rising-edge press detector on the debounced level.
module key_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the key; the level follows only after a long enough stable run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
    end else begin
      sync1_r   <= key;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CW'(DEBOUNCE_CYC)) begin
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press = level_r & ~level_d_r;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake movement controller: debounced direction keys with reversal rejection,
// pending/commit direction register, game-step timer and speed level.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int BASE_PERIOD  = 12500000,
  parameter int PERIOD_STEP  = 625000,
  parameter int MAX_LEVEL    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       update_head,
  input  logic       inc_length,
  input  logic       pause,
  input  logic       game_restart,
  output logic [2:0] dir,
  output logic       move_tick,
  output logic [3:0] speed_level
);

  localparam int TW = $clog2(BASE_PERIOD + 1);

  logic [3:0]    press_s;
  dir_e          dir_r;
  dir_e          pending_r;
  dir_e          next_dir_s;
  dir_e          press_dir_s;
  logic          press_valid_s;
  logic          accept_s;
  logic          eat_s;
  logic          inc_d_r;
  logic          tick_r;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] period_m1_s;
  logic [3:0]    speed_r;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up    (.clk(clk), .rst(rst), .key(key_up),    .press(press_s[0]));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_down  (.clk(clk), .rst(rst), .key(key_down),  .press(press_s[1]));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left  (.clk(clk), .rst(rst), .key(key_left),  .press(press_s[2]));
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (.clk(clk), .rst(rst), .key(key_right), .press(press_s[3]));

  // Pick one press by priority, judge it against the direction that will be in force.
  always_comb begin
    press_dir_s   = DIR_UP;
    press_valid_s = 1'b1;
    if (press_s[0]) begin
      press_dir_s = DIR_UP;
    end else if (press_s[1]) begin
      press_dir_s = DIR_DOWN;
    end else if (press_s[2]) begin
      press_dir_s = DIR_LEFT;
    end else if (press_s[3]) begin
      press_dir_s = DIR_RIGHT;
    end else begin
      press_valid_s = 1'b0;
    end
    if (update_head) begin
      next_dir_s = pending_r;
    end else begin
      next_dir_s = dir_r;
    end
    accept_s    = press_valid_s & ~dir_opposite(press_dir_s, next_dir_s);
    period_m1_s = TW'(BASE_PERIOD - 1 - int'(speed_r) * PERIOD_STEP);
    eat_s       = inc_length & ~inc_d_r & (speed_r < 4'(MAX_LEVEL));
  end

  // Direction commit, pending update, step timer and speed level.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r     <= DIR_UP;
      pending_r <= DIR_UP;
      timer_r   <= {TW{1'b0}};
      tick_r    <= 1'b0;
      speed_r   <= 4'd0;
      inc_d_r   <= 1'b0;
    end else begin
      inc_d_r <= inc_length;
      if (game_restart) begin
        dir_r     <= DIR_UP;
        pending_r <= DIR_UP;
        timer_r   <= {TW{1'b0}};
        tick_r    <= 1'b0;
        speed_r   <= 4'd0;
      end else begin
        if (update_head) dir_r <= pending_r;
        if (accept_s) pending_r <= press_dir_s;
        if (eat_s) speed_r <= speed_r + 4'd1;
        // >= rather than == so a period shortened mid-count still ticks once, next cycle.
        if (pause) begin
          tick_r <= 1'b0;
        end else if (timer_r >= period_m1_s) begin
          tick_r  <= 1'b1;
          timer_r <= {TW{1'b0}};
        end else begin
          tick_r  <= 1'b0;
          timer_r <= timer_r + TW'(1);
        end
      end
    end
  end

  assign dir         = dir_r;
  assign move_tick   = tick_r;
  assign speed_level = speed_r;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: behavioural model compared every
// cycle plus directed scenarios with hand-computed expectations.
module tb_snake_dir_ctrl;

  localparam int DEB  = 4;
  localparam int BASE = 20;
  localparam int STEP = 2;
  localparam int MAXL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = 4'b0000;          // 0 up, 1 down, 2 left, 3 right
  logic       update_head = 1'b0;
  logic       inc_length = 1'b0;
  logic       pause = 1'b0;
  logic       game_restart = 1'b0;
  logic [2:0] dir;
  logic       move_tick;
  logic [3:0] speed_level;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int n;

  snake_dir_ctrl #(
    .DEBOUNCE_CYC(DEB), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk), .rst(rst),
    .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]), .key_right(keys[3]),
    .update_head(update_head), .inc_length(inc_length), .pause(pause),
    .game_restart(game_restart),
    .dir(dir), .move_tick(move_tick), .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit         m_s1[4], m_s2[4], m_lvl[4], m_lvl_d[4];
  int         m_run[4];
  logic [2:0] m_dir, m_pend;
  int         m_el, m_spd;
  bit         m_tick, m_inc_d;

  function automatic logic [2:0] kdir(input int k);
    case (k)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] opp(input logic [2:0] d);
    case (d)
      3'b100: return 3'b110;
      3'b110: return 3'b100;
      3'b000: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit [3:0]   pr;
    logic [2:0] ref_d, cand;
    bit         found;
    int         per;
    if (rst) begin
      m_dir = 3'b100; m_pend = 3'b100; m_el = 0; m_tick = 0; m_spd = 0; m_inc_d = 0;
      for (int k = 0; k < 4; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_lvl_d[k] = 0; m_run[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) pr[k] = m_lvl[k] && !m_lvl_d[k];
      per = BASE - m_spd * STEP;
      if (game_restart) begin
        m_dir = 3'b100; m_pend = 3'b100; m_el = 0; m_tick = 0; m_spd = 0;
      end else begin
        ref_d = update_head ? m_pend : m_dir;
        found = 0;
        cand  = 3'b100;
        for (int k = 0; k < 4; k++) begin
          if (pr[k] && !found) begin
            found = 1;
            cand  = kdir(k);
          end
        end
        if (update_head) m_dir = m_pend;
        if (found && cand != opp(ref_d)) m_pend = cand;
        m_tick = 0;
        if (!pause) begin
          m_el++;
          if (m_el >= per) begin
            m_tick = 1;
            m_el   = 0;
          end
        end
        if (inc_length && !m_inc_d && m_spd < MAXL) m_spd++;
      end
      m_inc_d = inc_length;
      // a key level is accepted after DEB+1 consecutive disagreeing synced samples
      for (int k = 0; k < 4; k++) begin
        m_lvl_d[k] = m_lvl[k];
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB + 1) begin
            m_lvl[k] = m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = keys[k];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dir", 32'(dir), 32'(m_dir));
      check("model_tick", 32'(move_tick), 32'(m_tick));
      check("model_speed", 32'(speed_level), 32'(m_spd));
    end
  end

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!move_tick && cnt < 200);
    if (!move_tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: no move_tick within %0d cycles", cnt);
    end
  endtask

  task automatic press_key(input int k);
    keys[k] = 1'b1;
    cycles(8);
    keys[k] = 1'b0;
    cycles(10);
  endtask

  task automatic commit();
    update_head = 1'b1;
    cycles(1);
    update_head = 1'b0;
    cycles(1);
  endtask

  task automatic eat(input int len);
    inc_length = 1'b1;
    cycles(len);
    inc_length = 1'b0;
    cycles(2);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    cycles(1);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_dir", 32'(dir), 32'd4);
    check("rst_speed", 32'(speed_level), 32'd0);
    check("rst_tick", 32'(move_tick), 32'd0);
    wait_tick(n); check("first_tick", n, 32'd20);
    wait_tick(n); check("period_l0", n, 32'd20);

    // bouncing key never settles long enough
    for (int i = 0; i < 10; i++) begin
      keys[2] = ~keys[2];
      cycles(2);
    end
    commit(); check("bounce_ignored", 32'(dir), 32'd4);

    // clean hold: pending becomes LEFT exactly 7 cycles after the first sample
    keys[2] = 1'b1;
    cycles(7);
    update_head = 1'b1;
    cycles(1);
    keys[2] = 1'b0;
    check("latency_not_early", 32'(dir), 32'd4);
    cycles(1);
    update_head = 1'b0;
    check("left_commit", 32'(dir), 32'd0);
    cycles(12);

    // reversal rejection and last-press-wins
    press_key(0); commit(); check("up_commit", 32'(dir), 32'd4);
    press_key(1); commit(); check("down_rejected", 32'(dir), 32'd4);
    press_key(3); press_key(2); commit(); check("last_press_left", 32'(dir), 32'd0);

    // press in the same cycle as a commit is judged against the committed value
    press_key(0); commit(); press_key(3);
    check("pre_same_dir", 32'(dir), 32'd4);
    keys[2] = 1'b1;
    cycles(7);
    update_head = 1'b1;
    cycles(1);
    update_head = 1'b0;
    keys[2] = 1'b0;
    check("same_cycle_commit", 32'(dir), 32'd1);
    cycles(10);
    commit(); check("left_rejected", 32'(dir), 32'd1);

    // speed levels
    eat(5); check("speed_once", 32'(speed_level), 32'd1);
    wait_tick(n); wait_tick(n); check("period_l1", n, 32'd18);
    eat(1); eat(1); eat(1); eat(1);
    check("speed_sat", 32'(speed_level), 32'd3);
    wait_tick(n); wait_tick(n); check("period_l3", n, 32'd14);

    // restart and pause
    game_restart = 1'b1; cycles(1); game_restart = 1'b0;
    check("restart_speed0", 32'(speed_level), 32'd0);
    eat(1); eat(1); check("speed_l2", 32'(speed_level), 32'd2);
    wait_tick(n); wait_tick(n); check("period_l2", n, 32'd16);
    cycles(5);
    game_restart = 1'b1; cycles(1); game_restart = 1'b0;
    check("restart_level", 32'(speed_level), 32'd0);
    check("restart_dir", 32'(dir), 32'd4);
    wait_tick(n); check("restart_tick", n, 32'd20);
    cycles(5);
    pause = 1'b1; cycles(7); pause = 1'b0;
    wait_tick(n); check("pause_delay", n + 12, 32'd27);

    // reset mid-game discards an uncommitted turn
    press_key(3);
    rst = 1'b1; cycles(1); rst = 1'b0;
    commit(); check("rst_pending", 32'(dir), 32'd4);
    check("rst_mid_speed", 32'(speed_level), 32'd0);

    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
